// File: rtl/cache_pkg.sv
// cache_pkg: shared address field layout and line geometry of the 4-way cache.
// No ports; imported by the victim writeback buffer.
package cache_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int WORD_NUM = 4;
  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 11;
  localparam int INDEX_MSB = 10;
  localparam int INDEX_LSB = 4;
  localparam int WORD_MSB = 3;
  localparam int WORD_LSB = 2;
  localparam int BYTE_MSB = 1;
  localparam int BYTE_LSB = 0;
  typedef struct packed {
    logic [TAG_MSB:TAG_LSB] tag;
    logic [INDEX_MSB:INDEX_LSB] index;
    logic [WORD_MSB:WORD_LSB] word;
    logic [BYTE_MSB:BYTE_LSB] byte_sel;
  } adr_t;
endpackage

// File: rtl/wb_line_entry.sv
// wb_line_entry: one buffered victim line (address, words, fill mask).
// Ports: clk/rst; write port wr/clr/wr_line/wr_word/wr_dat; combinational
// match/read port match_line/rd_word -> match/rd_dat; raw line/mask/data views.
module wb_line_entry #(
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 28,
  parameter int WORD_NUM = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic clr,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic [OFFSET_WIDTH-1:0] wr_word,
  input  logic [WORD_WIDTH-1:0] wr_dat,
  input  logic [LINE_WIDTH-1:0] match_line,
  input  logic [OFFSET_WIDTH-1:0] rd_word,
  output logic match,
  output logic [WORD_WIDTH-1:0] rd_dat,
  output logic [LINE_WIDTH-1:0] line,
  output logic [WORD_NUM-1:0] mask,
  output logic [WORD_NUM-1:0][WORD_WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) mask <= '0;
    else mask <= clr ? '0 : mask | (wr ? WORD_NUM'(1) << wr_word : '0);
  end
  // the first word of a line (empty mask) latches the line address
  always_ff @(posedge clk) begin
    if (wr && mask == '0) line <= wr_line;
    if (wr) data[wr_word] <= wr_dat;
  end
  assign match = line == match_line;
  assign rd_dat = data[rd_word];
endmodule

// File: rtl/victim_writeback_buffer.sv
// victim_writeback_buffer: assembles evicted dirty lines and drains them to memory.
// Ports: vic_* victim word stream in (vic_ready_o back-pressure); wb_* word write
// req/ack to memory; snoop_* combinational lookup of buffered lines; full/empty/ovf status.
module victim_writeback_buffer #(
  parameter int WORD_WIDTH = cache_pkg::WORD_WIDTH,
  parameter int ADR_WIDTH = 32,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int WORD_NUM = cache_pkg::WORD_NUM,
  parameter int ENTRIES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic vic_valid_i,
  input  logic [ADR_WIDTH-1:0] vic_adr_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] vic_word_i,
  input  logic [WORD_WIDTH-1:0] vic_dat_i,
  output logic vic_ready_o,
  output logic wb_req_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [WORD_WIDTH-1:0] wb_dat_o,
  input  logic wb_ack_i,
  input  logic [ADR_WIDTH-1:0] snoop_adr_i,
  output logic snoop_hit_o,
  output logic snoop_busy_o,
  output logic [WORD_WIDTH-1:0] snoop_dat_o,
  output logic full_o,
  output logic empty_o,
  output logic ovf_o
);
  import cache_pkg::*;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int LSB = WORD_LSB + WORD_OFFSET_WIDTH;
  localparam int LW = ADR_WIDTH - LSB;
  localparam int PW = $clog2(ENTRIES);
  state_t state, state_n;
  logic [PW-1:0] wr_ptr, rd_ptr, src_e;
  logic [PW:0] count;
  logic [WORD_OFFSET_WIDTH-1:0] cnt, cnt_n, src_w;
  logic req_n, load, pop, we, commit, hit;
  logic [WORD_WIDTH-1:0] hit_dat;
  logic [ENTRIES-1:0] match;
  logic [LW-1:0] line [ENTRIES];
  logic [WORD_NUM-1:0] mask [ENTRIES];
  logic [WORD_NUM-1:0][WORD_WIDTH-1:0] data [ENTRIES];
  logic [WORD_WIDTH-1:0] rd_dat [ENTRIES];
  logic unused;
  assign unused = ^{vic_adr_i[LSB-1:0], snoop_adr_i[WORD_LSB-1:0]};
  assign we = vic_valid_i && vic_ready_o;
  assign commit = we && ((mask[wr_ptr] | (WORD_NUM'(1) << vic_word_i)) == '1);
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    wb_line_entry #(
      .WORD_WIDTH(WORD_WIDTH), .LINE_WIDTH(LW), .WORD_NUM(WORD_NUM), .OFFSET_WIDTH(WORD_OFFSET_WIDTH)
    ) u_entry (
      .clk(clk), .rst(rst),
      .wr(we && wr_ptr == PW'(i)), .clr(commit && wr_ptr == PW'(i)),
      .wr_line(vic_adr_i[ADR_WIDTH-1:LSB]), .wr_word(vic_word_i), .wr_dat(vic_dat_i),
      .match_line(snoop_adr_i[ADR_WIDTH-1:LSB]), .rd_word(snoop_adr_i[LSB-1:WORD_LSB]),
      .match(match[i]), .rd_dat(rd_dat[i]), .line(line[i]), .mask(mask[i]), .data(data[i])
    );
  end
  // walk committed entries oldest to newest so the newest match wins
  always_comb begin
    hit = 1'b0;
    hit_dat = '0;
    for (int k = 0; k < ENTRIES; k++)
      if ((PW+1)'(k) < count && match[rd_ptr + PW'(k)]) begin
        hit = 1'b1;
        hit_dat = rd_dat[rd_ptr + PW'(k)];
      end
  end
  assign snoop_busy_o = mask[wr_ptr] != '0 && line[wr_ptr] == snoop_adr_i[ADR_WIDTH-1:LSB];
  assign snoop_hit_o = hit && !snoop_busy_o;
  assign snoop_dat_o = snoop_hit_o ? hit_dat : '0;
  assign vic_ready_o = count < (PW+1)'(ENTRIES);
  assign full_o = count == (PW+1)'(ENTRIES);
  assign empty_o = count == '0 && mask[wr_ptr] == '0;
  // src_e/src_w select the word loaded into the registered wb outputs
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    req_n = wb_req_o;
    load = 1'b0;
    pop = 1'b0;
    src_e = rd_ptr;
    src_w = cnt;
    if (state == IDLE) begin
      if (count != '0) begin
        state_n = XFER;
        cnt_n = '0;
        src_w = '0;
        req_n = 1'b1;
        load = 1'b1;
      end
    end else if (wb_ack_i) begin
      cnt_n = cnt + WORD_OFFSET_WIDTH'(1);
      src_w = cnt_n;
      load = 1'b1;
      if (cnt == '1) begin
        pop = 1'b1;
        src_e = rd_ptr + PW'(1);
        if (count == (PW+1)'(1) && !commit) begin
          state_n = IDLE;
          req_n = 1'b0;
          load = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_o <= 1'b0;
      wb_req_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr_ptr <= wr_ptr + PW'(commit);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(commit) - (PW+1)'(pop);
      ovf_o <= ovf_o | (vic_valid_i && !vic_ready_o);
      wb_req_o <= req_n;
      if (load) begin
        wb_adr_o <= {line[src_e], src_w, {WORD_LSB{1'b0}}};
        // a line committing this edge may be read before its last word is stored
        wb_dat_o <= (we && wr_ptr == src_e && vic_word_i == src_w) ? vic_dat_i : data[src_e][src_w];
      end
    end
  end
endmodule

// File: tb/tb_victim_writeback_buffer.sv
// tb_victim_writeback_buffer: directed self-checking bench for victim_writeback_buffer.
module tb_victim_writeback_buffer;
  logic clk = 1'b0;
  logic rst;
  logic vic_valid_i;
  logic [31:0] vic_adr_i;
  logic [1:0] vic_word_i;
  logic [31:0] vic_dat_i;
  logic vic_ready_o;
  logic wb_req_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic wb_ack_i;
  logic [31:0] snoop_adr_i;
  logic snoop_hit_o;
  logic snoop_busy_o;
  logic [31:0] snoop_dat_o;
  logic full_o;
  logic empty_o;
  logic ovf_o;
  int nvec = 0;
  int nerr = 0;

  victim_writeback_buffer dut (
    .clk(clk), .rst(rst),
    .vic_valid_i(vic_valid_i), .vic_adr_i(vic_adr_i), .vic_word_i(vic_word_i), .vic_dat_i(vic_dat_i),
    .vic_ready_o(vic_ready_o),
    .wb_req_o(wb_req_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i),
    .snoop_adr_i(snoop_adr_i), .snoop_hit_o(snoop_hit_o), .snoop_busy_o(snoop_busy_o),
    .snoop_dat_o(snoop_dat_o), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    vic_valid_i = 1'b1;
    vic_adr_i = a;
    vic_word_i = w;
    vic_dat_i = d;
    tick;
    vic_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
    nvec++; if (wb_req_o !== 1'b0) begin nerr++; $display("FAIL reset_req got %b exp 0", wb_req_o); end
    nvec++; if (wb_adr_o !== 32'h0) begin nerr++; $display("FAIL reset_adr got %h exp 0", wb_adr_o); end
    nvec++; if (wb_dat_o !== 32'h0) begin nerr++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
    nvec++; if (vic_ready_o !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", vic_ready_o); end
    nvec++; if ({full_o, empty_o, ovf_o} !== 3'b010) begin nerr++; $display("FAIL reset_flags got %b exp 010", {full_o, empty_o, ovf_o}); end
    nvec++; if ({snoop_hit_o, snoop_busy_o} !== 2'b00) begin nerr++; $display("FAIL reset_snoop got %b exp 00", {snoop_hit_o, snoop_busy_o}); end
  endtask

  task automatic test_drain_order;
    logic [1:0] ord [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    wb_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'h0000_1230, ord[i], 32'hA0 + 32'(ord[i]));
      if (i == 0) begin
        nvec++; if (empty_o !== 1'b0) begin nerr++; $display("FAIL order_filling_empty got %b exp 0", empty_o); end
      end
    end
    nvec++; if (wb_req_o !== 1'b0) begin nerr++; $display("FAIL order_req_at_commit got %b exp 0", wb_req_o); end
    tick;
    for (int i = 0; i < 4; i++) begin
      nvec++; if ({wb_req_o, wb_adr_o, wb_dat_o} !== {1'b1, 32'h1230 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
        nerr++; $display("FAIL order_word%0d got req=%b adr=%h dat=%h exp req=1 adr=%h dat=%h",
                         i, wb_req_o, wb_adr_o, wb_dat_o, 32'h1230 + 32'(4 * i), 32'hA0 + 32'(i));
      end
      tick;
    end
    nvec++; if ({wb_req_o, empty_o} !== 2'b01) begin nerr++; $display("FAIL order_done got req/empty=%b exp 01", {wb_req_o, empty_o}); end
  endtask

  task automatic test_full_ovf;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h2000, 2'(i), 32'hB0 + 32'(i));
    for (int i = 0; i < 4; i++) push(32'h3000, 2'(i), 32'hC0 + 32'(i));
    nvec++; if ({full_o, vic_ready_o} !== 2'b10) begin nerr++; $display("FAIL full_flags got full/ready=%b exp 10", {full_o, vic_ready_o}); end
    push(32'h7000, 2'd0, 32'hDEAD);
    nvec++; if (ovf_o !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b exp 1", ovf_o); end
    snoop_adr_i = 32'h7000;
    #1;
    nvec++; if ({snoop_hit_o, snoop_busy_o} !== 2'b00) begin nerr++; $display("FAIL ovf_dropped got hit/busy=%b exp 00", {snoop_hit_o, snoop_busy_o}); end
    snoop_adr_i = 32'h3008;
    #1;
    nvec++; if ({snoop_hit_o, snoop_dat_o} !== {1'b1, 32'hC2}) begin nerr++; $display("FAIL full_snoop got hit=%b dat=%h exp hit=1 dat=000000c2", snoop_hit_o, snoop_dat_o); end
    wb_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nvec++; if ({wb_req_o, wb_adr_o, wb_dat_o} !== {1'b1, (i < 4 ? 32'h2000 : 32'h3000) + 32'(4 * (i % 4)), (i < 4 ? 32'hB0 : 32'hC0) + 32'(i % 4)}) begin
        nerr++; $display("FAIL full_drain%0d got req=%b adr=%h dat=%h", i, wb_req_o, wb_adr_o, wb_dat_o);
      end
      tick;
    end
    nvec++; if ({wb_req_o, empty_o, ovf_o} !== 3'b011) begin nerr++; $display("FAIL full_after got req/empty/ovf=%b exp 011", {wb_req_o, empty_o, ovf_o}); end
  endtask

  task automatic test_snoop;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h4000, 2'(i), 32'hD0 + 32'(i));
    snoop_adr_i = 32'h4008;
    #1;
    nvec++; if ({snoop_hit_o, snoop_busy_o, snoop_dat_o} !== {2'b10, 32'hD2}) begin
      nerr++; $display("FAIL snoop_hit got hit=%b busy=%b dat=%h exp 1 0 000000d2", snoop_hit_o, snoop_busy_o, snoop_dat_o);
    end
    push(32'h5000, 2'd0, 32'hE0);
    snoop_adr_i = 32'h5004;
    #1;
    nvec++; if ({snoop_hit_o, snoop_busy_o, snoop_dat_o} !== {2'b01, 32'h0}) begin
      nerr++; $display("FAIL snoop_busy got hit=%b busy=%b dat=%h exp 0 1 0", snoop_hit_o, snoop_busy_o, snoop_dat_o);
    end
    snoop_adr_i = 32'h6000;
    #1;
    nvec++; if ({snoop_hit_o, snoop_busy_o, snoop_dat_o} !== {2'b00, 32'h0}) begin
      nerr++; $display("FAIL snoop_miss got hit=%b busy=%b dat=%h exp 0 0 0", snoop_hit_o, snoop_busy_o, snoop_dat_o);
    end
    for (int i = 1; i < 4; i++) push(32'h5000, 2'(i), 32'hE0 + 32'(i));
    wb_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nvec++; if ({wb_req_o, wb_adr_o, wb_dat_o} !== {1'b1, (i < 4 ? 32'h4000 : 32'h5000) + 32'(4 * (i % 4)), (i < 4 ? 32'hD0 : 32'hE0) + 32'(i % 4)}) begin
        nerr++; $display("FAIL snoop_drain%0d got req=%b adr=%h dat=%h", i, wb_req_o, wb_adr_o, wb_dat_o);
      end
      tick;
    end
    nvec++; if (empty_o !== 1'b1) begin nerr++; $display("FAIL snoop_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] ord [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    wb_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h8000, 2'(i), 32'hF0 + 32'(i));
    for (int c = 1; c <= 9; c++) begin
      if (c >= 2 && c <= 5) begin
        vic_valid_i = 1'b1;
        vic_adr_i = 32'h9000;
        vic_word_i = ord[c-2];
        vic_dat_i = 32'h90 + 32'(ord[c-2]);
      end
      tick;
      vic_valid_i = 1'b0;
      if (c < 9) begin
        nvec++; if ({wb_req_o, wb_adr_o, wb_dat_o} !== {1'b1, (c < 5 ? 32'h8000 : 32'h9000) + 32'(4 * ((c - 1) % 4)), (c < 5 ? 32'hF0 : 32'h90) + 32'((c - 1) % 4)}) begin
          nerr++; $display("FAIL b2b_cycle%0d got req=%b adr=%h dat=%h", c, wb_req_o, wb_adr_o, wb_dat_o);
        end
      end
      if (c == 5) begin
        nvec++; if ({full_o, empty_o} !== 2'b00) begin nerr++; $display("FAIL b2b_count got full/empty=%b exp 00", {full_o, empty_o}); end
      end
    end
    nvec++; if ({wb_req_o, empty_o} !== 2'b01) begin nerr++; $display("FAIL b2b_done got req/empty=%b exp 01", {wb_req_o, empty_o}); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] ord [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    wb_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h1000, 2'(i), 32'h10 + 32'(i));
    tick;
    wb_ack_i = 1'b1;
    tick;
    nvec++; if (wb_adr_o !== 32'h1004) begin nerr++; $display("FAIL mid_word1 got adr=%h exp 00001004", wb_adr_o); end
    rst = 1'b1;
    wb_ack_i = 1'b0;
    tick;
    rst = 1'b0;
    nvec++; if ({wb_req_o, empty_o, full_o, ovf_o} !== 4'b0100) begin
      nerr++; $display("FAIL mid_reset got req/empty/full/ovf=%b exp 0100", {wb_req_o, empty_o, full_o, ovf_o});
    end
    wb_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hA000, ord[i], 32'h60 + 32'(ord[i]));
    tick;
    for (int i = 0; i < 4; i++) begin
      nvec++; if ({wb_req_o, wb_adr_o, wb_dat_o} !== {1'b1, 32'hA000 + 32'(4 * i), 32'h60 + 32'(i)}) begin
        nerr++; $display("FAIL mid_after%0d got req=%b adr=%h dat=%h", i, wb_req_o, wb_adr_o, wb_dat_o);
      end
      tick;
    end
    nvec++; if ({wb_req_o, empty_o} !== 2'b01) begin nerr++; $display("FAIL mid_done got req/empty=%b exp 01", {wb_req_o, empty_o}); end
  endtask

  initial begin
    rst = 1'b1;
    vic_valid_i = 1'b0;
    vic_adr_i = '0;
    vic_word_i = '0;
    vic_dat_i = '0;
    wb_ack_i = 1'b0;
    snoop_adr_i = '0;
    test_reset;
    test_drain_order;
    test_full_ovf;
    test_snoop;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/victim_writeback_buffer.md
Name: victim_writeback_buffer

Overview:
- Sits directly downstream of the 4-way set-associative cache.
- Consumes the per-word victim stream (data + word index) that the cache emits when evicting a dirty line, and assembles complete 4-word lines.
- Drains complete lines to memory as word writes over a req/ack handshake.
- Provides a snoop port so a cache miss can forward data from a line that has not yet been written back.

Parameters:
- WORD_WIDTH, 32, data word width
- ADR_WIDTH, 32, byte address width
- WORD_OFFSET_WIDTH, 2, word-in-line index width
- WORD_NUM, 4, words per line
- ENTRIES, 2, line entries in buffer (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- vic_valid_i  in  1  victim word strobe from cache
- vic_adr_i  in  ADR_WIDTH  victim line address; bits [31:4] used, sampled on first word of a line
- vic_word_i  in  WORD_OFFSET_WIDTH  word index of vic_dat_i
- vic_dat_i  in  WORD_WIDTH  victim word data
- vic_ready_o  out  1  buffer can accept victim words
- wb_req_o  out  1  memory write request
- wb_adr_o  out  ADR_WIDTH  write address {line[31:4], word, 2'b00}
- wb_dat_o  out  WORD_WIDTH  write data
- wb_ack_i  in  1  memory accepted current word
- snoop_adr_i  in  ADR_WIDTH  cache lookup address
- snoop_hit_o  out  1  committed line matches snoop_adr_i[31:4]
- snoop_busy_o  out  1  line still filling matches; cache must stall
- snoop_dat_o  out  WORD_WIDTH  word snoop_adr_i[3:2] of matching line
- full_o  out  1  count==ENTRIES
- empty_o  out  1  count==0 and no filling entry
- ovf_o  out  1  sticky: strobe received while full

Behaviour:
- Reset is synchronous and active-high (rst); clock is clk.
- Reset values: wb_req_o=0, wb_adr_o=0, wb_dat_o=0, vic_ready_o=1, full_o=0, empty_o=1, ovf_o=0. All entries are invalid and all fill masks are cleared.
- Storage: circular FIFO of ENTRIES lines, with wr_ptr, rd_ptr and count (width clog2(ENTRIES)+1). Each entry holds line address [31:4], 4 data words and a 4-bit fill mask.
- Fill:
  - On vic_valid_i with the mask at wr_ptr ==0, the entry captures vic_adr_i[31:4].
  - Every strobe writes data[vic_word_i] and sets mask bit vic_word_i.
  - Words may arrive in any order; the cache starts at the requested offset and wraps.
  - A duplicate word overwrites its data; the mask is unchanged.
- Commit:
  - The cycle the mask reaches 4'b1111 (including the completing strobe), the entry commits at the clock edge: count+1, wr_ptr+1 (wraps modulo ENTRIES), mask cleared.
- Full:
  - vic_ready_o = (count<ENTRIES).
  - A strobe while count==ENTRIES is ignored, and ovf_o is set to 1 until rst.
- Drain FSM states:
  - IDLE: if count>0, go to XFER with drain_cnt=0.
  - XFER: wb_req_o=1, wb_adr_o={line[rd_ptr],drain_cnt,2'b00}, wb_dat_o=data[rd_ptr][drain_cnt].
    - On wb_ack_i: drain_cnt+1.
    - If drain_cnt==3: pop (rd_ptr+1, count-1), then go to XFER again if count-1>0, else IDLE.
  - Outputs are registered. Words drain in order 0..3 regardless of arrival order.
  - wb_req_o stays high across all words of a line and across back-to-back lines.
  - adr/dat update the cycle after each ack.
- Latency:
  - Commit at edge N → wb_req_o=1 after edge N+1.
  - Minimum of 4 cycles per line with wb_ack_i held high.
- Simultaneous commit and pop in one cycle: count unchanged, both pointers advance.
- wb_ack_i while wb_req_o=0: ignored.
- Snoop (combinational):
  - Compares snoop_adr_i[31:4] against every committed entry; the newest match wins.
  - snoop_dat_o is 0 when there is no hit.
  - An entry popping this cycle still hits.
  - A match against the filling entry (mask !=0) gives snoop_busy_o=1 and snoop_hit_o=0.
- Reset mid-operation: wb_req_o drops after the next edge and all pending lines are discarded. The memory side must tolerate a request abandoned without an ack.

Decomposition:
- cache_pkg holds the shared address field constants (TAG 31:11, INDEX 10:4, WORD 3:2, BYTE 1:0), WORD_WIDTH and WORD_NUM.
- The drain FSM state encoding (IDLE, XFER) is local.
- One sub-module, wb_line_entry: single-line storage with address, data, mask, a write port and a combinational match/read port. It is instantiated ENTRIES times.

Test Plan:
- Words 2,3,0,1 of line 0x0000_1230 with data A2,A3,A0,A1, wb_ack_i high → wb writes 0x1230/A0, 0x1234/A1, 0x1238/A2, 0x123C/A3 in consecutive cycles. wb_req_o rises one cycle after commit; empty_o=1 after the last ack.
- Fill 2 lines with wb_ack_i=0 → full_o=1 and vic_ready_o=0. A 3rd strobe sets ovf_o=1, the contents are unchanged and ovf_o persists after the drain.
- Line 0x4000 committed, snoop 0x4008 → snoop_hit_o=1, snoop_dat_o=word2. Line 0x5000 with only word 0 written, snoop 0x5004 → snoop_busy_o=1, snoop_hit_o=0.
- A line completes in the same cycle as the final ack of another line → count stays 1 and the new line drains next with no gap in wb_req_o.
- rst asserted during XFER at word 1 → the cycle after, wb_req_o=0, empty_o=1, full_o=0; a subsequent line drains correctly from word 0.
